// File: rtl/inst_window_cache.sv
// rtl/inst_window_cache.sv - two-window instruction cache with demand fill and next-window prefetch
module inst_window_cache #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 32,
  parameter int                LINE_WORDS = 8,
  parameter logic [DATA_W-1:0] NOP        = 32'h00000000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Fetch_en,
  input  logic [ADDR_W-1:0] Address,
  input  logic              Flush,
  output logic [DATA_W-1:0] Instruction,
  output logic              Instr_valid,
  output logic              Stall,
  output logic              Mem_req,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [DATA_W-1:0] Mem_data,
  input  logic              Mem_valid
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PREFETCH = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] win [2][LINE_WORDS];
  logic [TAG_W-1:0]  base [2];
  logic [1:0]        valid;
  logic              last_used;
  logic              target;
  logic [OFF_W-1:0]  beat;

  logic [TAG_W-1:0]  tag;
  logic [TAG_W-1:0]  next_tag;
  logic [OFF_W-1:0]  offset;
  logic [1:0]        hit_w;
  logic              hit;
  logic              hit_idx;
  logic              pf_idx;
  logic              victim;
  logic              pf_needed;
  logic              mem_beat;
  logic              last_beat;
  logic              start_fill;
  logic              start_pf;

  assign tag      = Address[ADDR_W-1:OFF_W];
  assign offset   = Address[OFF_W-1:0];
  assign next_tag = tag + TAG_W'(1);
  assign victim   = ~last_used;

  // A window under fill/prefetch is never a hit source, even though its base is already set.
  always_comb begin
    hit_w = '0;
    for (int w = 0; w < 2; w++) begin
      hit_w[w] = Fetch_en && valid[w] && (base[w] == tag) &&
                 !((state != IDLE) && (target == 1'(w)));
    end
  end

  assign hit       = |hit_w;
  assign hit_idx   = ~hit_w[0];
  assign pf_idx    = ~hit_idx;
  assign pf_needed = hit && (offset >= OFF_W'(LINE_WORDS / 2)) &&
                     !(valid[pf_idx] && (base[pf_idx] == next_tag));

  assign Stall     = Fetch_en && !hit;
  assign Mem_req   = (state != IDLE);
  assign Mem_addr  = Mem_req ? {base[target], beat} : '0;
  assign mem_beat  = (state != IDLE) && Mem_valid;
  assign last_beat = mem_beat && (beat == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    start_pf   = 1'b0;
    case (state)
      IDLE: begin
        if (Fetch_en && !hit) begin
          state_nxt  = FILL;
          start_fill = 1'b1;
        end else if (pf_needed) begin
          state_nxt = PREFETCH;
          start_pf  = 1'b1;
        end
      end
      FILL, PREFETCH: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Flush) begin
      state_nxt  = IDLE;
      start_fill = 1'b0;
      start_pf   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_beat && !Flush) win[target][beat] <= Mem_data;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      valid       <= '0;
      beat        <= '0;
      last_used   <= 1'b1;
      target      <= 1'b0;
      base[0]     <= '0;
      base[1]     <= '0;
      Instruction <= NOP;
      Instr_valid <= 1'b0;
    end else if (Flush) begin
      valid       <= '0;
      beat        <= '0;
      Instruction <= NOP;
      Instr_valid <= 1'b0;
    end else begin
      Instr_valid <= hit;
      Instruction <= hit ? win[hit_idx][offset] : NOP;
      if (hit) last_used <= hit_idx;
      if (start_fill) begin
        target        <= victim;
        base[victim]  <= tag;
        valid[victim] <= 1'b0;
        beat          <= '0;
      end else if (start_pf) begin
        target        <= pf_idx;
        base[pf_idx]  <= next_tag;
        valid[pf_idx] <= 1'b0;
        beat          <= '0;
      end else if (mem_beat) begin
        beat <= beat + OFF_W'(1);
        if (last_beat) begin
          valid[target] <= 1'b1;
          beat          <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_window_cache.sv
// tb/tb_inst_window_cache.sv - self-checking bench for inst_window_cache
module tb_inst_window_cache;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_W = 32'h00000000;

  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Fetch_en = 1'b0;
  logic [ADDR_W-1:0] Address = '0;
  logic              Flush = 1'b0;
  logic [DATA_W-1:0] Instruction;
  logic              Instr_valid;
  logic              Stall;
  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_data = '0;
  logic              Mem_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 0;
  int resp_cnt = 0;
  bit spurious = 1'b0;
  logic [31:0] mem_key = '0;

  int stall_cnt [16];
  int accept_cyc [16];
  logic [ADDR_W-1:0] beat_q [$];
  logic [ADDR_W-1:0] burst_addr_q [$];
  int burst_cyc_q [$];
  bit mon_prev = 1'b0;

  inst_window_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(8), .NOP(NOP_W)) dut (
    .clk(clk), .Reset(Reset), .Fetch_en(Fetch_en), .Address(Address), .Flush(Flush),
    .Instruction(Instruction), .Instr_valid(Instr_valid), .Stall(Stall),
    .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_data(Mem_data), .Mem_valid(Mem_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return (32'h1000 + 32'(a)) ^ mem_key;
  endfunction

  // Backing memory: answers the current Mem_addr every lat+1 cycles; may also babble when idle.
  always @(posedge clk) begin
    #2;
    if (Mem_req) begin
      if (resp_cnt >= lat) begin
        Mem_valid = 1'b1;
        Mem_data  = word_of(Mem_addr);
        resp_cnt  = 0;
      end else begin
        Mem_valid = 1'b0;
        Mem_data  = 32'hDEADBEEF;
        resp_cnt++;
      end
    end else begin
      resp_cnt  = 0;
      Mem_valid = spurious;
      Mem_data  = 32'hBADBAD00;
    end
  end

  always @(posedge clk) begin
    #4;
    if (Mem_req && !mon_prev) begin
      burst_addr_q.push_back(Mem_addr);
      burst_cyc_q.push_back(cyc);
    end
    if (Mem_req && Mem_valid) beat_q.push_back(Mem_addr);
    mon_prev = Mem_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    Fetch_en = 1'b0;
    Flush = 1'b1;
    next_cycle();
    Flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    Fetch_en = 1'b0;
    #2;
    while (Mem_req && n < 300) begin
      next_cycle();
      #2;
      n++;
    end
    checks++;
    if (Mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: Mem_req=%b required 0 within 300 cycles", Mem_req);
    end
    next_cycle();
  endtask

  task automatic cpu_run(input logic [ADDR_W-1:0] start, input int n);
    int s;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = start + ADDR_W'(k);
      Address = a;
      Fetch_en = 1'b1;
      #2;
      s = 0;
      while (Stall && s < 200) begin
        next_cycle();
        #2;
        s++;
      end
      checks++;
      if (s >= 200) begin
        errors++;
        $display("FAIL cpu_stall_timeout: addr %h still stalled after %0d cycles", a, s);
      end
      stall_cnt[k] = s;
      accept_cyc[k] = cyc;
      next_cycle();
      checks++;
      if (Instr_valid !== 1'b1 || Instruction !== word_of(a)) begin
        errors++;
        $display("FAIL cpu_data: addr %h got valid=%b instr=%h required valid=1 instr=%h",
                 a, Instr_valid, Instruction, word_of(a));
      end
    end
    Fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) next_cycle();
    #2;
    checks++;
    if ({Instr_valid, Mem_req, Stall} !== 3'b000 || Instruction !== NOP_W || Mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_held: valid=%b req=%b stall=%b instr=%h addr=%h required 0,0,0,NOP,0",
               Instr_valid, Mem_req, Stall, Instruction, Mem_addr);
    end
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    checks++;
    if (Instr_valid !== 1'b0 || Instruction !== NOP_W || Mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: valid=%b instr=%h req=%b required 0,NOP,0", Instr_valid, Instruction, Mem_req);
    end
  endtask

  task automatic test_cold_fill();
    lat = 0;
    mem_key = '0;
    Address = 10'h010;
    Fetch_en = 1'b1;
    #2;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL cold_first_stall: Stall=%b required 1", Stall);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #2;
      checks++;
      if ({Mem_req, Stall, Instr_valid} !== 3'b110 || Mem_addr !== 10'(16 + i)) begin
        errors++;
        $display("FAIL cold_beat%0d: req=%b stall=%b valid=%b addr=%h required 1,1,0,%h",
                 i, Mem_req, Stall, Instr_valid, Mem_addr, 10'(16 + i));
      end
    end
    next_cycle();
    #2;
    checks++;
    if ({Mem_req, Stall} !== 2'b00) begin
      errors++;
      $display("FAIL cold_done: req=%b stall=%b required 0,0", Mem_req, Stall);
    end
    next_cycle();
    checks++;
    if (Instr_valid !== 1'b1 || Instruction !== 32'h00001010) begin
      errors++;
      $display("FAIL cold_instr: valid=%b instr=%h required 1,00001010", Instr_valid, Instruction);
    end
    Fetch_en = 1'b0;
  endtask

  task automatic test_sequential();
    flush_pulse();
    burst_addr_q.delete();
    burst_cyc_q.delete();
    lat = 1;
    cpu_run(10'h010, 16);
    for (int k = 1; k < 16; k++) begin
      if (k != 8) begin
        checks++;
        if (stall_cnt[k] !== 0) begin
          errors++;
          $display("FAIL seq_nostall: addr %h stalled %0d cycles required 0", 10'(16 + k), stall_cnt[k]);
        end
      end
    end
    checks++;
    if (stall_cnt[8] !== 13) begin
      errors++;
      $display("FAIL seq_remaining_beats: addr 018 stalled %0d cycles required 13", stall_cnt[8]);
    end
    checks++;
    if (burst_addr_q.size() < 2 || burst_addr_q[1] !== 10'h018 || burst_cyc_q[1] !== accept_cyc[4] + 1) begin
      errors++;
      $display("FAIL seq_prefetch_start: bursts=%0d second addr=%h cycle=%0d required 018 at cycle %0d",
               burst_addr_q.size(), (burst_addr_q.size() > 1) ? burst_addr_q[1] : 10'h3FF,
               (burst_cyc_q.size() > 1) ? burst_cyc_q[1] : -1, accept_cyc[4] + 1);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    flush_pulse();
    beat_q.delete();
    lat = 0;
    cpu_run(10'h3F8, 8);
    wait_idle();
    checks++;
    if (beat_q.size() !== 16) begin
      errors++;
      $display("FAIL wrap_beats: %0d beats required 16", beat_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (beat_q[i] !== 10'(10'h3F8 + i)) begin
          errors++;
          $display("FAIL wrap_addr%0d: got %h required %h", i, beat_q[i], 10'(10'h3F8 + i));
        end
      end
    end
    cpu_run(10'h000, 2);
    checks++;
    if (stall_cnt[0] !== 0 || stall_cnt[1] !== 0) begin
      errors++;
      $display("FAIL wrap_hit: stalls %0d,%0d required 0,0", stall_cnt[0], stall_cnt[1]);
    end
  endtask

  task automatic test_flush_midfill();
    int n;
    wait_idle();
    flush_pulse();
    lat = 0;
    Address = 10'h040;
    Fetch_en = 1'b1;
    #2;
    n = 0;
    while (!(Mem_req && Mem_addr == 10'h043) && n < 50) begin
      next_cycle();
      #2;
      n++;
    end
    checks++;
    if (n >= 50 || Mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_find_beat3: beat 3 not presented (n=%0d valid=%b) required within 50", n, Mem_valid);
    end
    Flush = 1'b1;
    Fetch_en = 1'b0;
    next_cycle();
    Flush = 1'b0;
    checks++;
    if (Instr_valid !== 1'b0 || Instruction !== NOP_W) begin
      errors++;
      $display("FAIL flush_outputs: valid=%b instr=%h required 0,NOP", Instr_valid, Instruction);
    end
    #2;
    checks++;
    if (Mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_drop: Mem_req=%b required 0", Mem_req);
    end
    mem_key = 32'h00AB0000;
    Address = 10'h043;
    Fetch_en = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_invalid: Stall=%b required 1", Stall);
    end
    next_cycle();
    #2;
    checks++;
    if (Mem_req !== 1'b1 || Mem_addr !== 10'h040) begin
      errors++;
      $display("FAIL flush_refill_beat0: req=%b addr=%h required 1,040", Mem_req, Mem_addr);
    end
    n = 0;
    while (Stall && n < 50) begin
      next_cycle();
      #2;
      n++;
    end
    next_cycle();
    checks++;
    if (Instr_valid !== 1'b1 || Instruction !== word_of(10'h043)) begin
      errors++;
      $display("FAIL flush_refill_data: valid=%b instr=%h required 1,%h", Instr_valid, Instruction, word_of(10'h043));
    end
    Fetch_en = 1'b0;
    wait_idle();
    mem_key = '0;
  endtask

  task automatic test_reset_midfill();
    int n;
    lat = 0;
    Address = 10'h080;
    Fetch_en = 1'b1;
    #2;
    n = 0;
    while (!(Mem_req && Mem_addr == 10'h083) && n < 50) begin
      next_cycle();
      #2;
      n++;
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (Mem_req !== 1'b0 || Mem_addr !== '0 || Instr_valid !== 1'b0 || Instruction !== NOP_W) begin
      errors++;
      $display("FAIL rst_mid_async: req=%b addr=%h valid=%b instr=%h required 0,0,0,NOP",
               Mem_req, Mem_addr, Instr_valid, Instruction);
    end
    Fetch_en = 1'b0;
    next_cycle();
    Reset = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      checks++;
      if (Mem_req !== 1'b0 || Instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_spurious%0d: req=%b valid=%b required 0,0", i, Mem_req, Instr_valid);
      end
      next_cycle();
    end
    spurious = 1'b0;
    Address = 10'h080;
    Fetch_en = 1'b1;
    #2;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_hit_080: Stall=%b required 1", Stall);
    end
    Address = 10'h043;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_hit_043: Stall=%b required 1", Stall);
    end
    Fetch_en = 1'b0;
    next_cycle();
    checks++;
    if (Instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_valid: Instr_valid=%b required 0", Instr_valid);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] pc, req_addr, exp_a, bbase;
    bit have_req, exp_v, prev_req, prev_flush;
    int bpos, held, r;
    bit filled [128];
    wait_idle();
    flush_pulse();
    for (int i = 0; i < 128; i++) filled[i] = 1'b0;
    pc = 10'($urandom_range(0, 1023));
    req_addr = pc;
    have_req = 0; exp_v = 0; exp_a = '0; prev_req = 0; prev_flush = 0;
    bbase = '0; bpos = 0; held = 0;
    for (int c = 0; c < 1500; c++) begin
      checks++;
      if (Instr_valid !== exp_v || Instruction !== (exp_v ? word_of(exp_a) : NOP_W)) begin
        errors++;
        $display("FAIL rand_instr c%0d: valid=%b instr=%h required %b,%h",
                 c, Instr_valid, Instruction, exp_v, exp_v ? word_of(exp_a) : NOP_W);
      end
      if (prev_flush) for (int i = 0; i < 128; i++) filled[i] = 1'b0;
      Flush = ($urandom_range(0, 59) == 0);
      if (!have_req && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 9);
        if (r < 7)       pc = pc + 10'd1;
        else if (r == 7) pc = 10'($urandom_range(0, 255));
        else if (r == 8) pc = 10'h3F0 + 10'($urandom_range(0, 15));
        else             pc = pc - 10'($urandom_range(0, 8));
        req_addr = pc;
        have_req = 1;
        held = 0;
      end
      Fetch_en = have_req;
      Address = req_addr;
      if (!Mem_req) lat = $urandom_range(0, 2);
      #2;
      if (Fetch_en && !Flush && !filled[Address[9:3]]) begin
        checks++;
        if (Stall !== 1'b1) begin
          errors++;
          $display("FAIL rand_cold_stall c%0d: addr %h Stall=%b required 1", c, Address, Stall);
        end
      end
      if (prev_flush) begin
        checks++;
        if (Mem_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_flush_req c%0d: Mem_req=%b required 0", c, Mem_req);
        end
      end
      if (Mem_req) begin
        if (!prev_req) begin
          checks++;
          if (Mem_addr[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL rand_burst_align c%0d: Mem_addr=%h required aligned", c, Mem_addr);
          end
          bbase = {Mem_addr[9:3], 3'd0};
          bpos = 0;
        end
        checks++;
        if (Mem_addr !== 10'(bbase + 10'(bpos))) begin
          errors++;
          $display("FAIL rand_burst_addr c%0d: Mem_addr=%h required %h", c, Mem_addr, 10'(bbase + 10'(bpos)));
        end
        if (Mem_valid && !Flush) begin
          bpos++;
          if (bpos == 8) filled[bbase[9:3]] = 1'b1;
        end
      end
      prev_req = Mem_req;
      exp_v = Fetch_en && !Stall && !Flush;
      exp_a = Address;
      if (exp_v) have_req = 0;
      else if (have_req) begin
        held++;
        if (held > 100) begin
          checks++;
          errors++;
          $display("FAIL rand_progress c%0d: addr %h stalled more than 100 cycles", c, req_addr);
          have_req = 0;
        end
      end
      prev_flush = Flush;
      next_cycle();
    end
    Flush = 1'b0;
    Fetch_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_sequential();
    test_wrap();
    test_flush_midfill();
    test_reset_midfill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
